// File: rtl/buzzer_scheduler.sv
// Buzzer scheduler: sole owner of the piezo pin. Arbitrates alarm/chime/beep requests
// and plays their fixed melodies through a shared tone/duration note engine.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | silent, waiting for a request
//  S_BEEP   | keypress beep, one note, then idle
//  S_CHIME  | hour chime, two notes each followed by a gap, then idle
//  S_ALARM  | four-note alarm melody looping, ring timer running
//  S_SNOOZE | silent, snooze timer running, then back to alarm note 0
module buzzer_scheduler #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int NOTE_MS   = 300,
    parameter int GAP_MS    = 50,
    parameter int BEEP_MS   = 50,
    parameter int SNOOZE_S  = 300,
    parameter int TIMEOUT_S = 60
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       alarm_hit,
    input  logic       chime_req,
    input  logic       beep_req,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       alarm_sound,
    output logic [1:0] active_src,
    output logic       snoozing,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEEP,
        S_CHIME,
        S_ALARM,
        S_SNOOZE
    } state_t;

    localparam logic [31:0] TICK_DIV    = 32'(CLK_HZ / 1000);
    localparam logic [19:0] NOTE_LEN    = 20'(NOTE_MS);
    localparam logic [19:0] GAP_LEN     = 20'(GAP_MS);
    localparam logic [19:0] BEEP_LEN    = 20'(BEEP_MS);
    localparam logic [19:0] SNOOZE_LEN  = 20'(SNOOZE_S * 1000);
    localparam logic [19:0] TIMEOUT_LEN = 20'(TIMEOUT_S * 1000);
    localparam logic [31:0] HALF_1000   = 32'(CLK_HZ / (2 * 1000));
    localparam logic [31:0] HALF_392    = 32'(CLK_HZ / (2 * 392));
    localparam logic [31:0] HALF_349    = 32'(CLK_HZ / (2 * 349));
    localparam logic [31:0] HALF_330    = 32'(CLK_HZ / (2 * 330));
    localparam logic [31:0] HALF_294    = 32'(CLK_HZ / (2 * 294));

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        gap_q, gap_d;
    logic [31:0] presc_q, presc_d;
    logic [19:0] dur_q, dur_d;
    logic [31:0] phase_q, phase_d;
    logic        sound_q, sound_d;
    logic [31:0] tpresc_q, tpresc_d;
    logic [19:0] tms_q, tms_d;
    logic [1:0]  src_q, src_d;
    logic        snz_q, snz_d;
    logic        busy_q, busy_d;

    logic        tone_state;
    logic        timer_state;
    logic        tick;
    logic        tmr_tick;
    logic        seg_end;
    logic        ring_done;
    logic        snooze_done;
    logic [19:0] seg_len;
    logic [31:0] half;
    logic        restart;
    logic        tmr_clr;

    function automatic logic [31:0] note_half(input state_t st, input logic [1:0] idx);
        logic [31:0] h;
        h = HALF_1000;
        if (st == S_CHIME) begin
            h = idx[0] ? HALF_392 : HALF_330;
        end else if (st == S_ALARM) begin
            case (idx)
                2'd0:    h = HALF_392;
                2'd1:    h = HALF_330;
                2'd2:    h = HALF_349;
                default: h = HALF_294;
            endcase
        end
        return h;
    endfunction

    assign tone_state  = (state_q == S_BEEP) || (state_q == S_CHIME) || (state_q == S_ALARM);
    assign timer_state = (state_q == S_ALARM) || (state_q == S_SNOOZE);
    assign half        = note_half(state_q, idx_q);
    assign seg_len     = gap_q ? GAP_LEN : ((state_q == S_BEEP) ? BEEP_LEN : NOTE_LEN);
    assign tick        = (presc_q == TICK_DIV - 32'd1);
    assign tmr_tick    = (tpresc_q == TICK_DIV - 32'd1);
    assign seg_end     = tick && (dur_q == seg_len - 20'd1);
    assign ring_done   = tmr_tick && (tms_q == TIMEOUT_LEN - 20'd1);
    assign snooze_done = tmr_tick && (tms_q == SNOOZE_LEN - 20'd1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        presc_d  = presc_q;
        dur_d    = dur_q;
        phase_d  = phase_q;
        sound_d  = sound_q;
        tpresc_d = tpresc_q;
        tms_d    = tms_q;
        restart  = 1'b0;
        tmr_clr  = 1'b0;

        // Note engine free-runs only while a melody is playing.
        if (tone_state) begin
            if (tick) begin
                presc_d = '0;
                if (dur_q != '1) dur_d = dur_q + 20'd1;
            end else begin
                presc_d = presc_q + 32'd1;
            end
            if (gap_q) begin
                phase_d = '0;
                sound_d = 1'b0;
            end else if (phase_q == half - 32'd1) begin
                phase_d = '0;
                sound_d = ~sound_q;
            end else begin
                phase_d = phase_q + 32'd1;
            end
        end

        if (timer_state) begin
            if (tmr_tick) begin
                tpresc_d = '0;
                if (tms_q != '1) tms_d = tms_q + 20'd1;
            end else begin
                tpresc_d = tpresc_q + 32'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (alarm_hit)      state_d = S_ALARM;
                else if (chime_req) state_d = S_CHIME;
                else if (beep_req)  state_d = S_BEEP;
            end
            S_BEEP: begin
                if (alarm_hit)      state_d = S_ALARM;
                else if (chime_req) state_d = S_CHIME;
                else if (seg_end)   state_d = S_IDLE;
            end
            S_CHIME: begin
                if (alarm_hit) begin
                    state_d = S_ALARM;
                end else if (seg_end) begin
                    if (!gap_q) begin
                        gap_d   = 1'b1;
                        restart = 1'b1;
                    end else if (idx_q == 2'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        gap_d   = 1'b0;
                        restart = 1'b1;
                    end
                end
            end
            S_ALARM: begin
                if (dismiss) begin
                    state_d = S_IDLE;
                end else if (snooze) begin
                    state_d = S_SNOOZE;
                end else if (ring_done) begin
                    state_d = S_IDLE;
                end else if (seg_end) begin
                    // The 2-bit index wrapping from 3 to 0 is what loops the melody.
                    gap_d   = ~gap_q;
                    idx_d   = gap_q ? idx_q + 2'd1 : idx_q;
                    restart = 1'b1;
                end
            end
            S_SNOOZE: begin
                if (dismiss)          state_d = S_IDLE;
                else if (snooze)      tmr_clr = 1'b1;
                else if (snooze_done) state_d = S_ALARM;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            restart = 1'b1;
            tmr_clr = 1'b1;
            idx_d   = 2'd0;
            gap_d   = 1'b0;
        end
        if (restart) begin
            presc_d = '0;
            dur_d   = '0;
            phase_d = '0;
            sound_d = 1'b0;
        end
        if (tmr_clr) begin
            tpresc_d = '0;
            tms_d    = '0;
        end

        case (state_d)
            S_BEEP:             src_d = 2'd1;
            S_CHIME:            src_d = 2'd2;
            S_ALARM, S_SNOOZE:  src_d = 2'd3;
            default:            src_d = 2'd0;
        endcase
        snz_d  = (state_d == S_SNOOZE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            gap_q    <= 1'b0;
            presc_q  <= '0;
            dur_q    <= '0;
            phase_q  <= '0;
            sound_q  <= 1'b0;
            tpresc_q <= '0;
            tms_q    <= '0;
            src_q    <= '0;
            snz_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            presc_q  <= presc_d;
            dur_q    <= dur_d;
            phase_q  <= phase_d;
            sound_q  <= sound_d;
            tpresc_q <= tpresc_d;
            tms_q    <= tms_d;
            src_q    <= src_d;
            snz_q    <= snz_d;
            busy_q   <= busy_d;
        end
    end

    assign alarm_sound = sound_q;
    assign active_src  = src_q;
    assign snoozing    = snz_q;
    assign busy        = busy_q;

endmodule

// File: doc/buzzer_scheduler.md
Name: buzzer_scheduler

Overview:
- Single owner of the piezo output `alarm_sound`. Arbitrates three sound requesters: alarm match, top-of-hour chime and keypress beep.
- Sequences fixed note melodies using per-note tone-divider and duration counters.
- Implements snooze, dismiss and auto-timeout for the alarm.
- Sits between the timekeeping/alarm-compare logic and the buzzer pin. Request inputs are single-cycle pulses from those blocks.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency; TICK_DIV = CLK_HZ/1000 cycles per ms tick.
- NOTE_MS, 300, duration of each melody note in ms.
- GAP_MS, 50, silence after each melody note in ms.
- BEEP_MS, 50, keypress beep duration in ms.
- SNOOZE_S, 300, snooze length in seconds.
- TIMEOUT_S, 60, max continuous alarm ringing in seconds before auto-stop.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- alarm_hit  in  1  one-cycle pulse: current time equals alarm time.
- chime_req  in  1  one-cycle pulse: hour rollover.
- beep_req  in  1  one-cycle pulse: button press.
- snooze  in  1  one-cycle pulse: user snooze.
- dismiss  in  1  one-cycle pulse: user stop.
- alarm_sound  out  1  square-wave buzzer drive.
- active_src  out  2  0 idle, 1 beep, 2 chime, 3 alarm.
- snoozing  out  1  high while in SNOOZE.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0) forces state IDLE; alarm_sound=0, active_src=0, snoozing=0, busy=0; all counters cleared. Reset mid-note silences the output immediately.
- States: IDLE, BEEP, CHIME, ALARM, SNOOZE. All outputs are registered. A request sampled at edge N changes state/outputs at edge N+1.
- Priority: alarm > chime > beep.
  - Higher-priority request preempts the current sound at the next edge.
  - Equal- or lower-priority requests arriving while busy are dropped, never queued.
  - In SNOOZE, beep and chime are ignored. alarm_hit in ALARM/SNOOZE is ignored.
- Note engine:
  - On every note start, clear the phase counter, ms prescaler and duration counter, and set alarm_sound=0.
  - HALF = CLK_HZ/(2*f), truncated. alarm_sound toggles every HALF cycles.
  - A note lasts exactly dur_ms*TICK_DIV cycles. A gap holds alarm_sound=0 for GAP_MS*TICK_DIV cycles.
- BEEP: 1000 Hz for BEEP_MS, no gap, then IDLE.
- CHIME: 330 Hz, gap, 392 Hz, gap, then IDLE.
- ALARM:
  - Loops the sequence 392, 330, 349, 294 Hz, each note followed by a gap, from index 0.
  - Ring timer counts ms from ALARM entry. When it reaches TIMEOUT_S*1000, go to IDLE.
  - snooze -> SNOOZE. dismiss -> IDLE. If both arrive in the same cycle, dismiss wins.
- SNOOZE:
  - alarm_sound=0, snoozing=1, active_src=3.
  - After SNOOZE_S*1000 ms, re-enter ALARM at note 0 with the ring timer cleared.
  - dismiss -> IDLE. A repeated snooze restarts the snooze timer.
- dismiss and snooze are ignored in IDLE, BEEP and CHIME.
- Widths:
  - Ms counters are 20 bits and must hold 300_000 without overflow.
  - Phase and prescaler counters are 32 bits.
  - Counters saturate at their terminal value and never wrap.

Test Plan (CLK_HZ=100_000, NOTE_MS=10, GAP_MS=2, BEEP_MS=5, SNOOZE_S=1, TIMEOUT_S=2):
- Reset held 20 cycles, then release -> all outputs 0. Assert reset_n=0 mid-alarm -> alarm_sound=0 and active_src=0 in the same cycle, before any clock edge.
- beep_req pulse at edge N -> active_src=1 at N+1; exactly 10 alarm_sound toggles at a 50-cycle spacing; IDLE at N+1+500.
- chime_req, then beep_req 100 cycles later -> beep dropped. Chime is 330 Hz (HALF=151) for 1000 cycles, 200-cycle silence, 392 Hz (HALF=127) for 1000 cycles, 200-cycle silence; active_src=0 after 2400 cycles.
- beep_req, then alarm_hit 200 cycles later -> active_src=3 on the next edge with alarm_sound=0. Notes at HALF 127/151/143/170, each lasting 1000 cycles with 200-cycle gaps, and the sequence repeats after 4800 cycles.
- In ALARM, snooze and dismiss pulsed in the same cycle -> IDLE, busy=0. Separately, snooze alone -> snoozing=1 and silence for 100_000 cycles, then ALARM resumes at 392 Hz.
- alarm_hit with no user input -> IDLE exactly 200_000 cycles after entry; chime_req during SNOOZE -> ignored, snoozing stays 1.
